// File: rtl/pcie_vc_pkg.sv
// Shared definitions for the virtual-channel transmit stage: flow-state encoding and
// word-layout helpers (the VC tag sits in the MSB, directly above the payload).
package pcie_vc_pkg;

  localparam int VC_COUNT = 2;

  typedef enum logic {
    FLOW_RUN  = 1'b0,
    FLOW_HOLD = 1'b1
  } flow_state_e;

  function automatic int word_width(input int bus_size);
    return bus_size + 1;
  endfunction

  function automatic int vc_tag_bit(input int bus_size);
    return bus_size;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Synchronous show-ahead FIFO used as the per-VC buffer. Push when full and pop when
// empty are ignored, so callers cannot corrupt the occupancy count.
module vc_fifo #(
  parameter int WIDTH      = 6,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // The extra count bit tells full from empty when the pointers coincide.
  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vc_flow_tx.sv
// Per-port transmit stage: buffers words per virtual channel and issues them to the switch
// under pause/continue flow control. Define VC_TX_STRICT_PRIO_EN for fixed VC0 priority.
module vc_flow_tx
  import pcie_vc_pkg::*;
#(
  parameter int BUS_SIZE   = 5,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BUS_SIZE:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                pause_vc0,
  input  logic                continue_vc0,
  input  logic                pause_vc1,
  input  logic                continue_vc1,
  output logic [BUS_SIZE:0]   data_out,
  output logic                valid_out,
  output logic                held_vc0,
  output logic                held_vc1,
  output logic                empty,
  output logic                drop_err
);

  localparam int W   = word_width(BUS_SIZE);
  localparam int TAG = vc_tag_bit(BUS_SIZE);

  // Upstream handshake: a word transfers on a cycle where in_valid && in_ready; in_ready
  // depends only on the target VC's fullness at cycle start. Downstream has no ready:
  // valid_out is a one-cycle strobe, and pause_vcN is the only back-pressure.
  logic                in_vc;
  logic [1:0]          push;
  logic [1:0]          pop;
  logic [1:0]          full;
  logic [1:0]          fifo_empty;
  logic [1:0]          pause_v;
  logic [1:0]          cont_v;
  logic [1:0]          elig;
  logic                any_pop;
  logic                sel;
  logic [W-1:0]        rd_data [VC_COUNT];
  logic [ADDR_WIDTH:0] count   [VC_COUNT];
  flow_state_e         state   [VC_COUNT];

  assign in_vc    = in_data[TAG];
  assign in_ready = in_vc ? !full[1] : !full[0];
  assign push[0]  = in_valid && in_ready && !in_vc;
  assign push[1]  = in_valid && in_ready && in_vc;
  assign pause_v  = {pause_vc1, pause_vc0};
  assign cont_v   = {continue_vc1, continue_vc0};

  for (genvar v = 0; v < VC_COUNT; v++) begin : g_vc
    vc_fifo #(.WIDTH(W), .ADDR_WIDTH(ADDR_WIDTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push[v]),
      .pop     (pop[v]),
      .wr_data (in_data),
      .rd_data (rd_data[v]),
      .full    (full[v]),
      .empty   (fifo_empty[v]),
      .count   (count[v])
    );
    // A pause blocks the pop in the very cycle it arrives.
    assign elig[v] = !fifo_empty[v] && (state[v] == FLOW_RUN) && !pause_v[v];
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_COUNT; v++) begin
      if (reset)           state[v] <= FLOW_RUN;
      else if (pause_v[v]) state[v] <= FLOW_HOLD;
      else if (cont_v[v])  state[v] <= FLOW_RUN;
    end
  end

  assign held_vc0 = (state[0] == FLOW_HOLD);
  assign held_vc1 = (state[1] == FLOW_HOLD);
  assign empty    = (count[0] == '0) && (count[1] == '0);
  assign any_pop  = |elig;

`ifdef VC_TX_STRICT_PRIO_EN
  always_comb begin
    sel = elig[0] ? 1'b0 : 1'b1;
    pop = '0;
    if (any_pop) pop[sel] = 1'b1;
  end
`else
  logic rr_ptr;

  always_comb begin
    sel = (&elig) ? rr_ptr : elig[1];
    pop = '0;
    if (any_pop) pop[sel] = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      drop_err  <= 1'b0;
`ifndef VC_TX_STRICT_PRIO_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      valid_out <= any_pop;
      if (any_pop) begin
        data_out <= rd_data[sel];
`ifndef VC_TX_STRICT_PRIO_EN
        rr_ptr   <= ~sel;
`endif
      end
      if (in_valid && !in_ready) drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_flow_tx.sv
// Bench for vc_flow_tx: hand-derived vector table, directed flow-control sequences with an
// ordered expected queue, and randomized traffic against a queue-based reference model.
module tb_vc_flow_tx;

  localparam int BUS_SIZE   = 5;
  localparam int ADDR_WIDTH = 2;
  localparam int W          = BUS_SIZE + 1;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         pause_vc0, continue_vc0, pause_vc1, continue_vc1;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         held_vc0, held_vc1;
  logic         empty;
  logic         drop_err;

  vc_flow_tx #(.BUS_SIZE(BUS_SIZE), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pause_vc0    (pause_vc0),
    .continue_vc0 (continue_vc0),
    .pause_vc1    (pause_vc1),
    .continue_vc1 (continue_vc1),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .held_vc0     (held_vc0),
    .held_vc1     (held_vc1),
    .empty        (empty),
    .drop_err     (drop_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per VC plus flow and arbitration bookkeeping.
  logic [W-1:0] mq0[$];
  logic [W-1:0] mq1[$];
  bit           m_held[2];
  int           m_turn;
  bit           m_valid;
  logic [W-1:0] m_data;
  bit           m_drop;
  logic         last_ready;

  // Scoreboard of words expected on data_out, in order.
  logic [W-1:0] exp_q[$];
  bit           sb_on = 1'b0;

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_held[0] = 1'b0;
    m_held[1] = 1'b0;
    m_turn    = 0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_drop    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0;
    pause_vc0 = 1'b0; continue_vc0 = 1'b0; pause_vc1 = 1'b0; continue_vc1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_empty", empty, 1);
    check("rst_held0", held_vc0, 0);
    check("rst_held1", held_vc1, 0);
    check("rst_drop", drop_err, 0);
  endtask

  // One clock cycle: drive, check in_ready before the edge, advance model, check outputs.
  task automatic drive_cycle(input logic iv, input logic [W-1:0] d,
                             input logic p0, input logic c0, input logic p1, input logic c1);
    bit rdy, e0, e1;
    int pick;
    logic [W-1:0] exp_w;
    in_valid = iv; in_data = d;
    pause_vc0 = p0; continue_vc0 = c0; pause_vc1 = p1; continue_vc1 = c1;
    @(negedge clk);
    rdy = d[W-1] ? (mq1.size() < DEPTH) : (mq0.size() < DEPTH);
    last_ready = in_ready;
    check("in_ready", in_ready, rdy);
    e0 = (mq0.size() != 0) && !m_held[0] && !p0;
    e1 = (mq1.size() != 0) && !m_held[1] && !p1;
    pick = -1;
    if (e0 && e1) begin
`ifdef VC_TX_STRICT_PRIO_EN
      pick = 0;
`else
      pick = m_turn;
`endif
    end else if (e0) pick = 0;
    else if (e1) pick = 1;
    @(posedge clk); #1;
    m_valid = (pick >= 0);
    if (pick == 0) begin m_data = mq0.pop_front(); m_turn = 1; end
    if (pick == 1) begin m_data = mq1.pop_front(); m_turn = 0; end
    if (iv) begin
      if (!rdy) m_drop = 1'b1;
      else if (d[W-1]) mq1.push_back(d);
      else mq0.push_back(d);
    end
    if (p0) m_held[0] = 1'b1; else if (c0) m_held[0] = 1'b0;
    if (p1) m_held[1] = 1'b1; else if (c1) m_held[1] = 1'b0;
    check("valid_out", valid_out, m_valid);
    check("data_out", data_out, m_data);
    check("held_vc0", held_vc0, m_held[0]);
    check("held_vc1", held_vc1, m_held[1]);
    check("empty", empty, (mq0.size() == 0) && (mq1.size() == 0));
    check("drop_err", drop_err, m_drop);
    if (sb_on && valid_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_extra: got word %0h expected none", data_out);
      end else begin
        exp_w = exp_q.pop_front();
        check("sb_order", data_out, exp_w);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         p0, c0, p1, c1;
    logic         ev;
    logic [W-1:0] ed;
    logic         eh0, eh1, eempty, erdy;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [W-1:0] d,
                              input logic p0, input logic c0, input logic p1, input logic c1,
                              input logic ev, input logic [W-1:0] ed,
                              input logic eh0, input logic eh1, input logic eempty,
                              input logic erdy);
    vec_t r;
    r.iv = iv; r.d = d; r.p0 = p0; r.c0 = c0; r.p1 = p1; r.c1 = c1;
    r.ev = ev; r.ed = ed; r.eh0 = eh0; r.eh1 = eh1; r.eempty = eempty; r.erdy = erdy;
    return r;
  endfunction

  vec_t tbl[10];

  initial begin
    // Two VC0 words stream out back to back, then pause/continue corner cases.
    tbl[0] = mk(1, 6'h1B, 0, 0, 0, 0,  0, 6'h00, 0, 0, 0, 1);
    tbl[1] = mk(1, 6'h0D, 0, 0, 0, 0,  1, 6'h1B, 0, 0, 0, 1);
    tbl[2] = mk(0, 6'h00, 0, 0, 0, 0,  1, 6'h0D, 0, 0, 1, 1);
    tbl[3] = mk(0, 6'h00, 0, 0, 0, 0,  0, 6'h0D, 0, 0, 1, 1);
    tbl[4] = mk(0, 6'h00, 0, 0, 1, 1,  0, 6'h0D, 0, 1, 1, 1);
    tbl[5] = mk(0, 6'h00, 0, 0, 1, 1,  0, 6'h0D, 0, 1, 1, 1);
    tbl[6] = mk(0, 6'h00, 0, 0, 0, 1,  0, 6'h0D, 0, 0, 1, 1);
    tbl[7] = mk(0, 6'h00, 1, 0, 0, 0,  0, 6'h0D, 1, 0, 1, 1);
    tbl[8] = mk(0, 6'h00, 1, 1, 0, 0,  0, 6'h0D, 1, 0, 1, 1);
    tbl[9] = mk(0, 6'h00, 0, 1, 0, 0,  0, 6'h0D, 0, 0, 1, 1);

    model_reset();
    do_reset();

    for (int i = 0; i < 10; i++) begin
      drive_cycle(tbl[i].iv, tbl[i].d, tbl[i].p0, tbl[i].c0, tbl[i].p1, tbl[i].c1);
      check($sformatf("tbl%0d_ready", i), last_ready, tbl[i].erdy);
      check($sformatf("tbl%0d_valid", i), valid_out, tbl[i].ev);
      check($sformatf("tbl%0d_data", i), data_out, tbl[i].ed);
      check($sformatf("tbl%0d_held0", i), held_vc0, tbl[i].eh0);
      check($sformatf("tbl%0d_held1", i), held_vc1, tbl[i].eh1);
      check($sformatf("tbl%0d_empty", i), empty, tbl[i].eempty);
    end

    // Equal-depth VC0/VC1 backlogs released together.
    do_reset();
    drive_cycle(0, '0, 1, 0, 1, 0);
    drive_cycle(1, 6'h03, 0, 0, 0, 0);
    drive_cycle(1, 6'h2B, 0, 0, 0, 0);
    drive_cycle(1, 6'h04, 0, 0, 0, 0);
    drive_cycle(1, 6'h2C, 0, 0, 0, 0);
    drive_cycle(1, 6'h05, 0, 0, 0, 0);
    drive_cycle(1, 6'h2D, 0, 0, 0, 0);
`ifdef VC_TX_STRICT_PRIO_EN
    exp_q = '{6'h03, 6'h04, 6'h05, 6'h2B, 6'h2C, 6'h2D};
`else
    exp_q = '{6'h03, 6'h2B, 6'h04, 6'h2C, 6'h05, 6'h2D};
`endif
    sb_on = 1'b1;
    drive_cycle(0, '0, 0, 1, 0, 1);
    check("rr_cont_latency", valid_out, 0);
    idle(8);
    check("rr_drained", exp_q.size(), 0);
    sb_on = 1'b0;

    // Pause pulse mid-stream and resume latency on VC0.
    do_reset();
    drive_cycle(0, '0, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) drive_cycle(1, W'(i), 0, 0, 0, 0);
    exp_q = '{6'h01, 6'h02, 6'h03, 6'h04};
    sb_on = 1'b1;
    drive_cycle(0, '0, 0, 1, 0, 0);
    check("p3_cont_k", valid_out, 0);
    idle(1);
    check("p3_first_valid", valid_out, 1);
    check("p3_first_data", data_out, 6'h01);
    drive_cycle(0, '0, 1, 0, 0, 0);
    check("p3_pause_gate", valid_out, 0);
    check("p3_held", held_vc0, 1);
    idle(3);
    check("p3_still_held", held_vc0, 1);
    drive_cycle(0, '0, 0, 1, 0, 0);
    check("p3_resume_k", valid_out, 0);
    idle(1);
    check("p3_resume_data", data_out, 6'h02);
    idle(4);
    check("p3_drained", exp_q.size(), 0);
    sb_on = 1'b0;

    // VC1 fills while held; overflow drops, VC0 still flows.
    do_reset();
    drive_cycle(0, '0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) drive_cycle(1, W'(6'h20 + i), 0, 0, 0, 0);
    check("p4_full_no_drop", drop_err, 0);
    drive_cycle(1, 6'h25, 0, 0, 0, 0);
    check("p4_full_ready", last_ready, 0);
    check("p4_drop", drop_err, 1);
    exp_q = '{6'h0A, 6'h21, 6'h22, 6'h23, 6'h24};
    sb_on = 1'b1;
    drive_cycle(1, 6'h0A, 0, 0, 0, 0);
    check("p4_vc0_ready", last_ready, 1);
    drive_cycle(0, '0, 0, 0, 0, 1);
    check("p4_vc0_sent", data_out, 6'h0A);
    idle(6);
    check("p4_drained", exp_q.size(), 0);
    check("p4_drop_sticky", drop_err, 1);
    sb_on = 1'b0;

    // Reset with words buffered and both VCs held.
    do_reset();
    drive_cycle(0, '0, 1, 0, 1, 0);
    drive_cycle(1, 6'h11, 0, 0, 0, 0);
    drive_cycle(1, 6'h12, 0, 0, 0, 0);
    drive_cycle(1, 6'h33, 0, 0, 0, 0);
    check("p6_pre_empty", empty, 0);
    do_reset();
    idle(3);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, W'($urandom_range(0, (1 << W) - 1)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
      if (i == 400) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
